// File: rtl/bus_responder.sv
// Target-side bus responder for the 6502 core: RAM, IO page (timer, NMI trigger),
// a req/ack bridged external read-only region, and unmapped space.
//
// state  | meaning
// IDLE   | no external read pending, accepting accesses
// WAIT   | external read outstanding, ready held low
// DONE   | external byte (or timeout 8'hFF) presented for one cycle
module bus_responder #(
    parameter int          RAM_AW    = 11,
    parameter logic [7:0]  IO_PAGE   = 8'hD0,
    parameter logic [15:0] EXT_BASE  = 16'hE000,
    parameter int          TIMEOUT   = 64,
    parameter int          NMI_PULSE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        irq,
    output logic        nmi,
    output logic        ext_req,
    output logic [15:0] ext_addr,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack
);
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam int NCW = $clog2(NMI_PULSE + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t state, state_next;

    logic [7:0]     mem [2**RAM_AW];
    logic [WCW-1:0] wcnt;
    logic [NCW-1:0] nmi_cnt;
    logic [15:0]    reload, count;
    logic           en, irqen, auto_rl;
    logic [1:0]     status;
    logic [7:0]     io_rdata;

    logic accept, is_ram, is_io, is_ext, ext_rd, io_wr;
    logic wr_rl_lo, wr_rl_hi, wr_ctrl, wr_stat, wr_nmi;
    logic wack, wto, tmr_set;

    assign accept = (state != S_WAIT);
    assign is_ram = (addr[15:RAM_AW] == '0);
    assign is_io  = !is_ram && (addr[15:8] == IO_PAGE);
    assign is_ext = !is_ram && !is_io && (addr >= EXT_BASE);
    assign ext_rd = accept && rw && is_ext;
    assign io_wr  = accept && !rw && is_io && (addr[7:4] == 4'h0);

    assign wr_rl_lo = io_wr && (addr[3:0] == 4'h0);
    assign wr_rl_hi = io_wr && (addr[3:0] == 4'h1);
    assign wr_ctrl  = io_wr && (addr[3:0] == 4'h2);
    assign wr_stat  = io_wr && (addr[3:0] == 4'h3);
    assign wr_nmi   = io_wr && (addr[3:0] == 4'h4);

    // An ack on the expiry cycle takes precedence over the timeout.
    assign wack    = (state == S_WAIT) && ext_ack;
    assign wto     = (state == S_WAIT) && !ext_ack && (wcnt == WCW'(TIMEOUT));
    assign tmr_set = en && (count == 16'h0000);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: state_next = ext_rd ? S_WAIT : S_IDLE;
            S_WAIT:         if (wack || wto) state_next = S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready   = (state != S_WAIT);
        ext_req = (state == S_WAIT);
    end

    always_comb begin
        io_rdata = 8'h00;
        if (addr[7:4] == 4'h0) begin
            case (addr[3:0])
                4'h0:    io_rdata = count[7:0];
                4'h1:    io_rdata = count[15:8];
                4'h2:    io_rdata = {5'b0, auto_rl, irqen, en};
                4'h3:    io_rdata = {6'b0, status};
                default: io_rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !rw && is_ram) mem[addr[RAM_AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata    <= 8'h00;
            ext_addr <= 16'h0000;
            wcnt     <= '0;
            reload   <= 16'h0000;
            count    <= 16'h0000;
            en       <= 1'b0;
            irqen    <= 1'b0;
            auto_rl  <= 1'b0;
            status   <= 2'b00;
            irq      <= 1'b0;
            nmi_cnt  <= '0;
        end else begin
            if (ext_rd) ext_addr <= addr;
            wcnt <= (state == S_WAIT) ? wcnt + WCW'(1) : '0;

            if (wack)     rdata <= ext_rdata;
            else if (wto) rdata <= 8'hFF;
            else if (accept && rw) begin
                if (is_ram)      rdata <= mem[addr[RAM_AW-1:0]];
                else if (is_io)  rdata <= io_rdata;
                else if (!is_ext) rdata <= 8'hFF;
            end

            if (en) begin
                if (count == 16'h0000) begin
                    if (auto_rl) count <= reload;
                    else         en    <= 1'b0;
                end else begin
                    count <= count - 16'd1;
                end
            end
            if (wr_rl_lo) reload[7:0]  <= wdata;
            if (wr_rl_hi) reload[15:8] <= wdata;
            if (wr_ctrl) begin
                en      <= wdata[0];
                irqen   <= wdata[1];
                auto_rl <= wdata[2];
                if (wdata[0] && !en) count <= reload;
            end

            status[0] <= tmr_set | (status[0] & ~(wr_stat & wdata[0]));
            status[1] <= wto     | (status[1] & ~(wr_stat & wdata[1]));
            irq       <= status[0] & irqen;

            if (wr_nmi)                nmi_cnt <= NCW'(NMI_PULSE);
            else if (nmi_cnt != '0)    nmi_cnt <= nmi_cnt - NCW'(1);
        end
    end

    assign nmi = (nmi_cnt != '0);
endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: vector table for single-cycle accesses,
// hand sequences for external handshake, timeout, timer IRQ, NMI and reset.
module tb_bus_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ready, irq, nmi, ext_req;
    logic [15:0] ext_addr;
    logic [7:0]  ext_rdata;
    logic        ext_ack;

    int checks = 0;
    int errors = 0;

    bus_responder dut (
        .clk(clk), .rst(rst), .addr(addr), .rw(rw), .wdata(wdata),
        .rdata(rdata), .ready(ready), .irq(irq), .nmi(nmi),
        .ext_req(ext_req), .ext_addr(ext_addr),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic        r;
        logic [7:0]  d;
        logic [7:0]  exp_rdata;
        logic        chk_rdata;
    } vec_t;

    vec_t vec [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ignored write to unmapped space: leaves rdata and all state untouched.
    task automatic idle();
        addr = 16'h9000; rw = 1'b0; wdata = 8'h00;
    endtask

    task automatic bus(input logic [15:0] a, input logic r, input logic [7:0] d);
        addr = a; rw = r; wdata = d;
        tick();
        idle();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue an external read and hold it until ready returns; ack_at<0 means no ack.
    task automatic ext_read(input logic [15:0] a, input int ack_at, input logic [7:0] d,
                            output int low);
        addr = a; rw = 1'b1; wdata = 8'h00;
        tick();
        chk("ext_addr", {16'h0, ext_addr}, {16'h0, a});
        chk("ext_req_w0", {31'h0, ext_req}, 32'h1);
        low = 0;
        for (int c = 0; c < 200; c++) begin
            if (ready) break;
            low++;
            if (c == ack_at) begin
                ext_ack = 1'b1; ext_rdata = d;
            end
            tick();
            ext_ack = 1'b0; ext_rdata = 8'h00;
        end
    endtask

    initial begin
        int low, hi;

        vec[0]  = '{16'h0123, 1'b0, 8'h5A, 8'h00, 1'b0};
        vec[1]  = '{16'h0123, 1'b1, 8'h00, 8'h5A, 1'b1};
        vec[2]  = '{16'h9000, 1'b1, 8'h00, 8'hFF, 1'b1};
        vec[3]  = '{16'h07FF, 1'b0, 8'h3C, 8'h00, 1'b0};
        vec[4]  = '{16'h07FF, 1'b1, 8'h00, 8'h3C, 1'b1};
        vec[5]  = '{16'h0800, 1'b1, 8'h00, 8'hFF, 1'b1};
        vec[6]  = '{16'hD010, 1'b1, 8'h00, 8'h00, 1'b1};
        vec[7]  = '{16'hD000, 1'b0, 8'h34, 8'h00, 1'b0};
        vec[8]  = '{16'hD000, 1'b1, 8'h00, 8'h00, 1'b1};
        vec[9]  = '{16'hDFFF, 1'b1, 8'h00, 8'hFF, 1'b1};
        vec[10] = '{16'hE000, 1'b0, 8'h77, 8'h00, 1'b0};
        vec[11] = '{16'h0123, 1'b1, 8'h00, 8'h5A, 1'b1};

        rst = 1'b1; ext_ack = 1'b0; ext_rdata = 8'h00;
        idle();
        tick(); tick();
        chk("rst_rdata",    {24'h0, rdata},    32'h00);
        chk("rst_ready",    {31'h0, ready},    32'h1);
        chk("rst_irq",      {31'h0, irq},      32'h0);
        chk("rst_nmi",      {31'h0, nmi},      32'h0);
        chk("rst_ext_req",  {31'h0, ext_req},  32'h0);
        chk("rst_ext_addr", {16'h0, ext_addr}, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            bus(vec[i].a, vec[i].r, vec[i].d);
            chk($sformatf("vec%0d_ready", i), {31'h0, ready}, 32'h1);
            if (vec[i].chk_rdata)
                chk($sformatf("vec%0d_rdata", i), {24'h0, rdata}, {24'h0, vec[i].exp_rdata});
        end

        // External read, ack three cycles after ext_req rises.
        ext_read(16'hFFFC, 3, 8'h80, low);
        chk("ext_low_cycles", low, 4);
        chk("ext_done_ready", {31'h0, ready}, 32'h1);
        chk("ext_done_req",   {31'h0, ext_req}, 32'h0);
        chk("ext_done_rdata", {24'h0, rdata}, 32'h80);
        idle(); tick();

        // Timeout: no ack at all.
        ext_read(16'hE800, -1, 8'h00, low);
        chk("to_low_cycles", low, 65);
        chk("to_rdata", {24'h0, rdata}, 32'hFF);
        idle(); tick();
        bus(16'hD003, 1'b1, 8'h00);
        chk("to_status", {24'h0, rdata}, 32'h02);
        bus(16'hD003, 1'b0, 8'h02);
        bus(16'hD003, 1'b1, 8'h00);
        chk("to_status_clr", {24'h0, rdata}, 32'h00);

        // Ack on the expiry cycle: real data, no timeout flag.
        ext_read(16'hF000, 64, 8'h11, low);
        chk("race_low_cycles", low, 65);
        chk("race_rdata", {24'h0, rdata}, 32'h11);
        idle(); tick();
        bus(16'hD003, 1'b1, 8'h00);
        chk("race_status", {24'h0, rdata}, 32'h00);

        // Timer: RELOAD=3, CTRL=EN|IRQEN|AUTO written in cycle N.
        bus(16'hD000, 1'b0, 8'h03);
        bus(16'hD001, 1'b0, 8'h00);
        bus(16'hD002, 1'b0, 8'h07);          // now N+1
        tick(); tick(); tick(); tick();      // N+5
        chk("tmr_irq_n5", {31'h0, irq}, 32'h0);
        tick();                              // N+6
        chk("tmr_irq_n6", {31'h0, irq}, 32'h1);
        tick(); tick();                      // N+8, an expiry cycle
        bus(16'hD003, 1'b0, 8'h01);          // clear collides with set
        bus(16'hD003, 1'b1, 8'h00);          // N+10
        chk("tmr_clr_race_status", {24'h0, rdata}, 32'h01);
        chk("tmr_clr_race_irq", {31'h0, irq}, 32'h1);
        bus(16'hD003, 1'b0, 8'h01);          // N+11
        bus(16'hD003, 1'b1, 8'h00);          // N+12
        chk("tmr_clr_status", {24'h0, rdata}, 32'h00);
        chk("tmr_clr_irq", {31'h0, irq}, 32'h0);
        tick(); tick();                      // N+14
        chk("tmr_repeat_irq", {31'h0, irq}, 32'h1);
        bus(16'hD002, 1'b0, 8'h00);
        bus(16'hD003, 1'b0, 8'h01);
        tick(); tick();
        chk("tmr_off_irq", {31'h0, irq}, 32'h0);

        // NMI single pulse.
        bus(16'hD004, 1'b0, 8'h00);
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (nmi) hi++;
            tick();
        end
        chk("nmi_single", hi, 4);

        // NMI retrigger two cycles in.
        bus(16'hD004, 1'b0, 8'h00);
        hi = nmi ? 1 : 0;
        tick();
        if (nmi) hi++;
        bus(16'hD004, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            if (nmi) hi++;
            tick();
        end
        chk("nmi_retrigger", hi, 6);

        // Reset during an external wait.
        bus(16'hD004, 1'b0, 8'h00);
        addr = 16'hFFFC; rw = 1'b1;
        tick();
        chk("rstw_ext_req_before", {31'h0, ext_req}, 32'h1);
        tick();
        rst = 1'b1;
        idle();
        tick();
        chk("rstw_ext_req", {31'h0, ext_req}, 32'h0);
        chk("rstw_ready",   {31'h0, ready},   32'h1);
        chk("rstw_irq",     {31'h0, irq},     32'h0);
        chk("rstw_nmi",     {31'h0, nmi},     32'h0);
        chk("rstw_rdata",   {24'h0, rdata},   32'h00);
        rst = 1'b0;
        tick();
        bus(16'hD004, 1'b1, 8'h00);
        bus(16'h0123, 1'b1, 8'h00);
        chk("rstw_ram_ready", {31'h0, ready}, 32'h1);
        chk("rstw_ram_rdata", {24'h0, rdata}, 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Target-side bus block for the 6502 core's synchronous memory interface.
- Decodes each core access into one of four regions: on-chip RAM, an IO register page holding a timer and an NMI trigger, a slow external read-only region bridged through a req/ack handshake, or unmapped space.
- Generates the core's `ready`, `irq` and `nmi` inputs.

Parameters:
- RAM_AW, 11, RAM address width; RAM occupies 0x0000..2^RAM_AW-1.
- IO_PAGE, 8'hD0, high byte of the IO page; registers are selected by addr[3:0].
- EXT_BASE, 16'hE000, addresses >= EXT_BASE go to the external port.
- TIMEOUT, 64, maximum WAIT cycles before an external read is aborted.
- NMI_PULSE, 4, cycles that nmi is held high after a trigger write.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- addr  in  16  core address, valid in the issue cycle.
- rw  in  1  1 = read, 0 = write.
- wdata  in  8  core write data.
- rdata  out  8  read data to core data_i.
- ready  out  1  rdata valid this cycle.
- irq  out  1  level interrupt to core.
- nmi  out  1  NMI pulse to core.
- ext_req  out  1  external read request (level).
- ext_addr  out  16  registered external address.
- ext_rdata  in  8  external read data, valid with ext_ack.
- ext_ack  in  1  single-cycle acknowledge.

Behaviour:
- Reset values: rdata=0, ready=1, irq=0, nmi=0, ext_req=0, ext_addr=0, state=IDLE, all IO registers 0. RAM contents are not reset.
- Issue cycle N: addr/rw/wdata are sampled at the clock edge ending cycle N. The initiator holds addr/rw stable while ready=0.
- RAM and IO reads: rdata is valid and ready=1 in cycle N+1 (1-cycle latency, no wait states).
- Writes: committed at the end of the issue cycle. ready is not lowered for writes.
- Writes to the EXT region and to unmapped space are ignored.
- Unmapped reads return 8'hFF. Reads of IO page offsets with addr[7:4]!=0 return 8'h00.
- External read FSM (states IDLE, WAIT, DONE):
  - IDLE: an EXT read issued in cycle N moves to WAIT. In cycle N+1, ext_req=1, ext_addr=addr, ready=0.
  - WAIT: ext_req=1, ready=0, and a wait counter increments each cycle.
    - On ext_ack: latch ext_rdata and go to DONE.
    - If the counter reaches TIMEOUT with no ack: latch 8'hFF, set STATUS[1], go to DONE.
  - DONE (one cycle): ready=1, rdata=latched byte, ext_req=0. A new access issued in DONE is accepted exactly as in IDLE; next state is WAIT for an EXT read, otherwise IDLE.
  - An ack arriving in the same cycle as the timeout expiry wins: real data, no STATUS[1].
  - ext_ack outside WAIT is ignored.
- IO registers (offset: function):
  - 0 / 1: RELOAD low/high on write. A read returns the current COUNT low/high.
  - 2: CTRL. bit0 EN, bit1 IRQEN, bit2 AUTO. A write that takes EN from 0 to 1 loads COUNT from RELOAD.
  - 3: STATUS. bit0 timer pending, bit1 ext timeout. Write 1 to clear each bit.
  - 4: NMI trigger. Any write drives nmi=1 for exactly NMI_PULSE cycles starting the next cycle. A write while the pulse is active restarts the count.
- Timer:
  - While EN=1, COUNT decrements each clk.
  - When COUNT==0 while EN=1: set STATUS[0]; if AUTO, COUNT<=RELOAD, else EN<=0.
  - COUNT is 16-bit and does not wrap below 0.
  - RELOAD=0 with AUTO=1 sets pending every cycle.
  - Writes to RELOAD do not disturb a running COUNT.
- irq = STATUS[0] & IRQEN, registered.
- Simultaneous timer set and software clear of STATUS[0]: the set wins.
- Reset mid-WAIT: the FSM returns to IDLE; ext_req drops and ready=1 in the cycle after rst is sampled.

Test Plan:
- RAM round trip: write 8'h5A to 0x0123, then read 0x0123 -> rdata=8'h5A with ready=1 one cycle after the read issue. Read 0x9000 -> 8'hFF.
- External read: read 0xFFFC with ext_ack 3 cycles after ext_req rises (ext_rdata=8'h80) -> ext_addr=0xFFFC, ready=0 for 4 cycles, then one DONE cycle with rdata=8'h80, ready=1, ext_req=0.
- Timeout: EXT read with ext_ack never asserted -> ready low for TIMEOUT+1 cycles; then rdata=8'hFF, and a subsequent read of 0xD003 returns bit1=1. Writing 8'h02 to 0xD003 clears it.
- Timer IRQ: RELOAD=0x0003, CTRL=0x07 -> irq rises about 5 cycles after the CTRL write and repeats every 4 cycles until STATUS is cleared. A clear landing on the expiry cycle leaves the pending bit set.
- NMI: write to 0xD004 -> nmi high exactly 4 cycles. A second write during the pulse extends it to 4 cycles from the second write.
- Reset mid-WAIT: assert rst during an ext wait -> next cycle ext_req=0, ready=1, irq=0, nmi=0. A later RAM read behaves normally.
